// File: rtl/jt89_pkg.sv
// Shared definitions for the JT89 PSG register controller: channel codes,
// register-type bits and the latched-register pointer layout.
package jt89_pkg;

    typedef enum logic [1:0] {
        CH_T0    = 2'd0,
        CH_T1    = 2'd1,
        CH_T2    = 2'd2,
        CH_NOISE = 2'd3
    } ch_e;

    localparam logic       TYP_TONE   = 1'b0;
    localparam logic       TYP_VOL    = 1'b1;
    localparam logic [3:0] VOL_SILENT = 4'hF;

    // Latched-register pointer, laid out exactly as din[6:4] of a latch byte.
    typedef struct packed {
        ch_e  ch;
        logic typ;
    } ptr_t;

endpackage

// File: rtl/jt89_busy_timer.sv
// READY handshake model: after an accepted write, READY stays low for
// BUSY_CYC clk_en pulses.
module jt89_busy_timer #(
    parameter int BUSY_CYC = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    input  logic start,
    output logic ready
);

    logic [5:0] cnt_q, cnt_d;
    logic       ready_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = 6'(BUSY_CYC);
        end else if (clk_en && cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q   <= 6'd0;
            ready_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d == 6'd0);
        end
    end

    assign ready = ready_q;

endmodule

// File: rtl/jt89_ctrl.sv
// SN76489-style latch/data byte decoder and register file driving the JT89
// tone channels, attenuators and noise generator.
module jt89_ctrl
    import jt89_pkg::*;
#(
    parameter int BUSY_CYC = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3,
    output logic [2:0] noise_ctrl,
    output logic       noise_rst
);

    logic [9:0] tone_q[3], tone_d[3];
    logic [3:0] vol_q[4],  vol_d[4];
    logic [2:0] noise_q,   noise_d;
    logic       nrst_q,    nrst_d;
    ptr_t       ptr_q,     ptr_d;
    ptr_t       sel;
    logic       accept;

    assign accept = wr & ready;

    always_comb begin
        tone_d  = tone_q;
        vol_d   = vol_q;
        noise_d = noise_q;
        ptr_d   = ptr_q;
        nrst_d  = 1'b0;
        // A latch byte addresses its own target; a data byte reuses the pointer.
        sel = din[7] ? ptr_t'(din[6:4]) : ptr_q;
        if (accept) begin
            if (din[7]) ptr_d = sel;
            if (sel.typ == TYP_VOL) begin
                vol_d[sel.ch] = din[3:0];
            end else if (sel.ch == CH_NOISE) begin
                noise_d = din[2:0];
                nrst_d  = 1'b1;
            end else if (din[7]) begin
                tone_d[sel.ch][3:0] = din[3:0];
            end else begin
                tone_d[sel.ch][9:4] = din[5:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these arrays are a handful of flops, not RAM, so every entry gets a defined reset value.
            for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
            for (int i = 0; i < 4; i++) vol_q[i]  <= VOL_SILENT;
            noise_q <= 3'd0;
            nrst_q  <= 1'b0;
            ptr_q   <= '{ch: CH_T0, typ: TYP_TONE};
        end else begin
            tone_q  <= tone_d;
            vol_q   <= vol_d;
            noise_q <= noise_d;
            nrst_q  <= nrst_d;
            ptr_q   <= ptr_d;
        end
    end

    jt89_busy_timer #(.BUSY_CYC(BUSY_CYC)) u_busy (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .start  (accept),
        .ready  (ready)
    );

    assign tone0      = tone_q[0];
    assign tone1      = tone_q[1];
    assign tone2      = tone_q[2];
    assign vol0       = vol_q[0];
    assign vol1       = vol_q[1];
    assign vol2       = vol_q[2];
    assign vol3       = vol_q[3];
    assign noise_ctrl = noise_q;
    assign noise_rst  = nrst_q;

endmodule

// File: tb/tb_jt89_ctrl.sv
// Self-checking bench for jt89_ctrl: directed scenarios plus a randomized run
// against a byte-level model of the latch/data protocol and READY window.
module tb_jt89_ctrl;

    localparam int BUSY = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] vol0, vol1, vol2, vol3;
    logic [2:0] noise_ctrl;
    logic       noise_rst;

    int errors = 0;
    int checks = 0;

    jt89_ctrl #(.BUSY_CYC(BUSY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .wr         (wr),
        .din        (din),
        .ready      (ready),
        .tone0      (tone0),
        .tone1      (tone1),
        .tone2      (tone2),
        .vol0       (vol0),
        .vol1       (vol1),
        .vol2       (vol2),
        .vol3       (vol3),
        .noise_ctrl (noise_ctrl),
        .noise_rst  (noise_rst)
    );

    always #5 clk = ~clk;

    logic [9:0] dut_tone[3];
    logic [3:0] dut_vol[4];
    assign dut_tone[0] = tone0;
    assign dut_tone[1] = tone1;
    assign dut_tone[2] = tone2;
    assign dut_vol[0]  = vol0;
    assign dut_vol[1]  = vol1;
    assign dut_vol[2]  = vol2;
    assign dut_vol[3]  = vol3;

    // Reference model: register contents, pointer and remaining busy pulses.
    logic [9:0] m_tone[3];
    logic [3:0] m_vol[4];
    logic [2:0] m_noise;
    logic       m_nrst;
    int         m_ch;
    logic       m_typ;
    int         m_busy;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
        for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
        m_noise = 3'd0;
        m_nrst  = 1'b0;
        m_ch    = 0;
        m_typ   = 1'b0;
        m_busy  = 0;
    endtask

    task automatic model_write(input logic [7:0] d);
        if (d[7]) begin
            m_ch  = int'(d[6:5]);
            m_typ = d[4];
        end
        if (m_typ) begin
            m_vol[m_ch] = d[3:0];
        end else if (m_ch == 3) begin
            m_noise = d[2:0];
            m_nrst  = 1'b1;
        end else if (d[7]) begin
            m_tone[m_ch] = {m_tone[m_ch][9:4], d[3:0]};
        end else begin
            m_tone[m_ch] = {d[5:0], m_tone[m_ch][3:0]};
        end
    endtask

    // One clk cycle: drive, take the edge, advance the model, settle off-edge.
    task automatic tick(input logic w, input logic [7:0] d, input logic ce);
        logic acc;
        wr = w;
        din = d;
        clk_en = ce;
        acc = w && (m_busy == 0);
        @(posedge clk);
        m_nrst = 1'b0;
        if (acc) begin
            model_write(d);
            m_busy = BUSY;
        end else if (ce && m_busy > 0) begin
            m_busy--;
        end
        #1;
        wr = 1'b0;
    endtask

    // Idle until ready rises; n = cycles spent low. clk_en pulses every 'period' cycles.
    task automatic wait_ready(input int period, output int n);
        n = 0;
        for (int k = 1; k <= 2000; k++) begin
            tick(1'b0, 8'h00, (k % period) == 0);
            if (ready === 1'b1) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            errors++;
            $display("FAIL wait_ready: ready stuck low, got %b required 1", ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({tone0, tone1, tone2} !== 30'd0) begin
            errors++;
            $display("FAIL reset_tone: got %h required 0", {tone0, tone1, tone2});
        end
        checks++;
        if ({vol0, vol1, vol2, vol3} !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_vol: got %h required ffff", {vol0, vol1, vol2, vol3});
        end
        checks++;
        if ({noise_ctrl, noise_rst, ready} !== 5'b000_0_1) begin
            errors++;
            $display("FAIL reset_misc: got %b required 00001", {noise_ctrl, noise_rst, ready});
        end
    endtask

    task automatic test_tone();
        int n;
        tick(1'b1, 8'h8E, 1'b1);
        checks++;
        if (tone0 !== 10'h00E || ready !== 1'b0) begin
            errors++;
            $display("FAIL tone_latch: got tone0=%h ready=%b required 00e/0", tone0, ready);
        end
        wait_ready(1, n);
        checks++;
        if (n != BUSY) begin
            errors++;
            $display("FAIL tone_busy1: got %0d required %0d", n, BUSY);
        end
        tick(1'b1, 8'h0F, 1'b1);
        checks++;
        if (tone0 !== 10'h0FE) begin
            errors++;
            $display("FAIL tone_data: got %h required 0fe", tone0);
        end
        wait_ready(1, n);
        checks++;
        if (n != BUSY) begin
            errors++;
            $display("FAIL tone_busy2: got %0d required %0d", n, BUSY);
        end
    endtask

    task automatic test_volume();
        int n;
        tick(1'b1, 8'hB3, 1'b1);
        checks++;
        if (vol1 !== 4'h3) begin
            errors++;
            $display("FAIL vol_latch: got %h required 3", vol1);
        end
        wait_ready(1, n);
        tick(1'b1, 8'h05, 1'b1);
        checks++;
        if (vol1 !== 4'h5 || tone1 !== m_tone[1]) begin
            errors++;
            $display("FAIL vol_data: got vol1=%h tone1=%h required 5/%h", vol1, tone1, m_tone[1]);
        end
        wait_ready(1, n);
    endtask

    task automatic test_noise();
        int n;
        tick(1'b1, 8'hE5, 1'b1);
        checks++;
        if (noise_ctrl !== 3'b101 || noise_rst !== 1'b1) begin
            errors++;
            $display("FAIL noise_latch: got ctrl=%b rst=%b required 101/1", noise_ctrl, noise_rst);
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (noise_rst !== 1'b0) begin
            errors++;
            $display("FAIL noise_pulse: got %b required 0", noise_rst);
        end
        wait_ready(1, n);
        tick(1'b1, 8'h02, 1'b1);
        checks++;
        if (noise_ctrl !== 3'b010 || noise_rst !== 1'b1) begin
            errors++;
            $display("FAIL noise_data: got ctrl=%b rst=%b required 010/1", noise_ctrl, noise_rst);
        end
        wait_ready(1, n);
    endtask

    task automatic test_busy_drop();
        int n;
        tick(1'b1, 8'h81, 1'b1);
        for (int k = 1; k < 10; k++) tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h90, 1'b1);
        checks++;
        if (vol0 !== 4'hF || ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_mid: got vol0=%h ready=%b required f/0", vol0, ready);
        end
        for (int k = 11; k < BUSY; k++) tick(1'b0, 8'h00, 1'b1);
        // Write collides with the final clk_en pulse: must be dropped.
        tick(1'b1, 8'h90, 1'b1);
        checks++;
        if (vol0 !== 4'hF || ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_final: got vol0=%h ready=%b required f/1", vol0, ready);
        end
        tick(1'b1, 8'h9F, 1'b1);
        checks++;
        if (vol0 !== 4'hF || ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_after: got vol0=%h ready=%b required f/0", vol0, ready);
        end
        wait_ready(1, n);
        checks++;
        if (n != BUSY) begin
            errors++;
            $display("FAIL busy_fresh: got %0d required %0d", n, BUSY);
        end
        // Pointer now targets vol0, so a data byte lands there.
        tick(1'b1, 8'h06, 1'b1);
        checks++;
        if (vol0 !== 4'h6) begin
            errors++;
            $display("FAIL ptr_vol0: got %h required 6", vol0);
        end
        wait_ready(4, n);
        checks++;
        if (n != 4 * BUSY) begin
            errors++;
            $display("FAIL busy_slow: got %0d required %0d", n, 4 * BUSY);
        end
        tick(1'b1, 8'h87, 1'b0);
        for (int k = 0; k < 50; k++) tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_freeze: got %b required 0", ready);
        end
        wait_ready(1, n);
        checks++;
        if (n != BUSY) begin
            errors++;
            $display("FAIL busy_resume: got %0d required %0d", n, BUSY);
        end
    endtask

    task automatic test_reset_mid_busy();
        tick(1'b1, 8'hC7, 1'b1);
        for (int k = 0; k < 5; k++) tick(1'b0, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ready !== 1'b1 || tone2 !== 10'd0 || tone0 !== 10'd0 || vol0 !== 4'hF) begin
            errors++;
            $display("FAIL rst_mid: got ready=%b tone2=%h tone0=%h vol0=%h required 1/0/0/f",
                     ready, tone2, tone0, vol0);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b1, 8'h9A, 1'b1);
        checks++;
        if (vol0 !== 4'hA || ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_next: got vol0=%h ready=%b required a/0", vol0, ready);
        end
    endtask

    task automatic test_random();
        logic w;
        logic ce;
        for (int c = 0; c < 3000; c++) begin
            w  = ($urandom % 3) == 0;
            ce = ($urandom % 2) == 0;
            tick(w, 8'($urandom), ce);
            checks++;
            if (ready !== (m_busy == 0) || noise_rst !== m_nrst || noise_ctrl !== m_noise) begin
                errors++;
                $display("FAIL rand_ctl @%0d: got ready=%b nrst=%b noise=%b required %b/%b/%b",
                         c, ready, noise_rst, noise_ctrl, m_busy == 0, m_nrst, m_noise);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_tone[i] !== m_tone[i]) begin
                    errors++;
                    $display("FAIL rand_tone%0d @%0d: got %h required %h", i, c, dut_tone[i], m_tone[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dut_vol[i] !== m_vol[i]) begin
                    errors++;
                    $display("FAIL rand_vol%0d @%0d: got %h required %h", i, c, dut_vol[i], m_vol[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_volume();
        test_noise();
        test_busy_drop();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
